// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel down-counting timer: register offsets,
// MODE encodings and CTRL/STATUS bit positions.
package timer_pkg;

   typedef enum logic [1:0] {
      RegCtrl   = 2'd0,
      RegPreset = 2'd1,
      RegCount  = 2'd2,
      RegStatus = 2'd3
   } reg_off_e;

   localparam logic [1:0] ModeOneShot    = 2'b00;
   localparam logic [1:0] ModeAutoReload = 2'b01;

   localparam int unsigned CtrlEnBit     = 0;
   localparam int unsigned CtrlModeLsb   = 1;
   localparam int unsigned CtrlImBit     = 3;
   localparam int unsigned StatusPendBit = 0;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL, PRESET, COUNT and PEND state with terminal-count,
// one-shot stop and auto-reload behaviour.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl_we,
   input  logic             preset_we,
   input  logic             status_we,
   input  logic [CNT_W-1:0] wd,
   output logic [31:0]      ctrl,
   output logic [CNT_W-1:0] preset,
   output logic [CNT_W-1:0] count,
   output logic             pend,
   output logic             irq
);

   logic             en_q, en_d;
   logic [1:0]       mode_q, mode_d;
   logic             im_q, im_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pend_q, pend_d;
   logic             tc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q     <= 1'b0;
         mode_q   <= ModeOneShot;
         im_q     <= 1'b0;
         preset_q <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
      end else begin
         en_q     <= en_d;
         mode_q   <= mode_d;
         im_q     <= im_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;
      tc       = 1'b0;

      if (en_q) begin
         if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
         end else if (count_q == CNT_W'(1)) begin
            count_d = '0;
            tc      = 1'b1;
            // Only MODE 01 keeps running; 00, 10 and 11 all stop at zero.
            if (mode_q != ModeAutoReload) en_d = 1'b0;
         end else if (mode_q == ModeAutoReload && preset_q != '0) begin
            count_d = preset_q;
         end
      end

      if (status_we && wd[StatusPendBit]) pend_d = 1'b0;
      if (tc) pend_d = 1'b1;

      if (ctrl_we) begin
         en_d   = wd[CtrlEnBit];
         mode_d = wd[CtrlModeLsb +: 2];
         im_d   = wd[CtrlImBit];
      end

      // A PRESET write overrides the counting result on the same edge.
      if (preset_we) begin
         preset_d = wd;
         count_d  = wd;
      end
   end

   assign ctrl   = {28'b0, im_q, mode_q, en_q};
   assign preset = preset_q;
   assign count  = count_q;
   assign pend   = pend_q;
   assign irq    = pend_q & im_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: register address decode, read mux and interrupt
// reduction around N_CH independent timer channels.
module multi_timer
   import timer_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 32,
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH_W+1:0] dev_addr,
   input  logic            we,
   input  logic [31:0]     dev_wd,
   output logic [31:0]     dev_rd,
   output logic [N_CH-1:0] irq,
   output logic            irq_any
);

   logic [CH_W-1:0]  ch_sel;
   reg_off_e         reg_sel;
   logic [31:0]      ctrl_rd   [N_CH];
   logic [CNT_W-1:0] preset_rd [N_CH];
   logic [CNT_W-1:0] count_rd  [N_CH];
   logic [N_CH-1:0]  pend;
   logic             unused_wd;

   assign ch_sel    = dev_addr[CH_W+1:2];
   assign reg_sel   = reg_off_e'(dev_addr[1:0]);
   assign unused_wd = ^dev_wd;

   // Channel indices >= N_CH match no instance, so they read 0 and drop writes.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic hit;
      assign hit = we && (ch_sel == CH_W'(g));

      timer_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .ctrl_we   (hit && (reg_sel == RegCtrl)),
         .preset_we (hit && (reg_sel == RegPreset)),
         .status_we (hit && (reg_sel == RegStatus)),
         .wd        (dev_wd[CNT_W-1:0]),
         .ctrl      (ctrl_rd[g]),
         .preset    (preset_rd[g]),
         .count     (count_rd[g]),
         .pend      (pend[g]),
         .irq       (irq[g])
      );
   end

   always_comb begin
      dev_rd = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_sel == CH_W'(i)) begin
            unique case (reg_sel)
               RegCtrl:   dev_rd = ctrl_rd[i];
               RegPreset: dev_rd = 32'(preset_rd[i]);
               RegCount:  dev_rd = 32'(count_rd[i]);
               RegStatus: dev_rd = {31'b0, pend[i]};
            endcase
         end
      end
   end

   assign irq_any = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: a 4-channel instance for the timing scenarios
// and a 3-channel, 16-bit instance for out-of-range channel and width checks.
module tb_multi_timer;

   logic        clk, rst;
   logic        we, we3;
   logic [3:0]  dev_addr, a3;
   logic [31:0] dev_wd, wd3, dev_rd, rdat3;
   logic [3:0]  irq;
   logic [2:0]  irq3;
   logic        irq_any, irq_any3;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] obs[$];
   int          total = 0;
   int          bad = 0;

   multi_timer #(.N_CH(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .dev_addr(dev_addr), .we(we), .dev_wd(dev_wd),
      .dev_rd(dev_rd), .irq(irq), .irq_any(irq_any)
   );

   multi_timer #(.N_CH(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst(rst), .dev_addr(a3), .we(we3), .dev_wd(wd3),
      .dev_rd(rdat3), .irq(irq3), .irq_any(irq_any3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1);
   end

   task automatic sb_push(input string n, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sb.push_back(e);
   endtask

   // Writes commit on the next rising edge; the task returns at the following falling edge.
   task automatic wr(input int ch, input int r, input logic [31:0] d);
      dev_addr = 4'(ch * 4 + r);
      dev_wd   = d;
      we       = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input int ch, input int r);
      dev_addr = 4'(ch * 4 + r);
      #1;
      obs.push_back(dev_rd);
   endtask

   task automatic rd_irq;
      obs.push_back({28'b0, irq});
      obs.push_back({31'b0, irq_any});
   endtask

   task automatic wr3(input int ch, input int r, input logic [31:0] d);
      a3  = 4'(ch * 4 + r);
      wd3 = d;
      we3 = 1'b1;
      @(negedge clk);
      we3 = 1'b0;
   endtask

   task automatic rd3(input int ch, input int r);
      a3 = 4'(ch * 4 + r);
      #1;
      obs.push_back(rdat3);
   endtask

   task automatic test_reset;
      exp_t e;
      logic [31:0] got;
      for (int ch = 0; ch < 4; ch++) begin
         for (int r = 0; r < 4; r++) begin
            sb_push($sformatf("reset_ch%0d_reg%0d", ch, r), 32'h0);
            rd(ch, r);
         end
      end
      sb_push("reset_irq", 32'h0);
      sb_push("reset_irq_any", 32'h0);
      rd_irq();
      sb_push("reset_irq3", 32'h0);
      obs.push_back({29'b0, irq3});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_one_shot;
      exp_t e;
      logic [31:0] got;
      wr(0, 1, 32'd5);
      wr(0, 0, 32'h9);
      for (int i = 0; i < 5; i++) begin
         sb_push($sformatf("os_count_step%0d", i), 32'(4 - i));
         @(negedge clk);
         rd(0, 2);
      end
      sb_push("os_pend", 32'h1);
      rd(0, 3);
      sb_push("os_irq", 32'h1);
      sb_push("os_irq_any", 32'h1);
      rd_irq();
      sb_push("os_en_cleared", 32'h8);
      rd(0, 0);
      @(negedge clk);
      sb_push("os_count_holds", 32'h0);
      rd(0, 2);
      wr(0, 3, 32'h0);
      sb_push("os_w0_no_effect", 32'h1);
      rd(0, 3);
      wr(0, 3, 32'h1);
      sb_push("os_w1c", 32'h0);
      rd(0, 3);
      sb_push("os_irq_cleared", 32'h0);
      sb_push("os_irq_any_cleared", 32'h0);
      rd_irq();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_auto_reload;
      exp_t e;
      logic [31:0] got;
      int exp_cnt[8]  = '{2, 1, 0, 3, 2, 1, 0, 3};
      int exp_pend[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
      wr(1, 1, 32'd3);
      wr(1, 0, 32'hB);
      for (int i = 0; i < 8; i++) begin
         sb_push($sformatf("ar_count_step%0d", i), 32'(exp_cnt[i]));
         sb_push($sformatf("ar_pend_step%0d", i), 32'(exp_pend[i]));
         sb_push($sformatf("ar_irq_step%0d", i), (exp_pend[i] != 0) ? 32'h2 : 32'h0);
         @(negedge clk);
         we = 1'b0;
         rd(1, 2);
         rd(1, 3);
         obs.push_back({28'b0, irq});
         // Clear PEND between the two terminal counts.
         if (i == 3) begin
            dev_addr = 4'(1 * 4 + 3);
            dev_wd   = 32'h1;
            we       = 1'b1;
         end
      end
      wr(1, 0, 32'h0);
      wr(1, 3, 32'h1);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_collision;
      exp_t e;
      logic [31:0] got;
      // MODE=10 must behave as one-shot and read back as written.
      wr(2, 1, 32'd2);
      wr(2, 0, 32'h5);
      @(negedge clk);
      sb_push("col_count_before", 32'h1);
      rd(2, 2);
      wr(2, 3, 32'h1);
      sb_push("col_w1c_count", 32'h0);
      rd(2, 2);
      sb_push("col_w1c_pend_set_wins", 32'h1);
      rd(2, 3);
      sb_push("col_mode10_ctrl", 32'h4);
      rd(2, 0);
      sb_push("col_masked_irq", 32'h0);
      obs.push_back({28'b0, irq});
      wr(2, 3, 32'h1);
      sb_push("col_pend_cleared", 32'h0);
      rd(2, 3);
      wr(2, 1, 32'd3);
      wr(2, 0, 32'h1);
      @(negedge clk);
      @(negedge clk);
      wr(2, 1, 32'd7);
      sb_push("col_preset_count", 32'h7);
      rd(2, 2);
      sb_push("col_preset_pend", 32'h1);
      rd(2, 3);
      sb_push("col_preset_en_clear", 32'h0);
      rd(2, 0);
      @(negedge clk);
      sb_push("col_preset_count_held", 32'h7);
      rd(2, 2);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_mask;
      exp_t e;
      logic [31:0] got;
      // ch3 starts one edge earlier with a preset one larger, so both expire together.
      wr(0, 1, 32'd2);
      wr(3, 1, 32'd3);
      wr(3, 0, 32'h1);
      wr(0, 0, 32'h9);
      @(negedge clk);
      sb_push("mask_irq_before", 32'h0);
      sb_push("mask_irq_any_before", 32'h0);
      rd_irq();
      @(negedge clk);
      sb_push("mask_irq_expiry", 32'h1);
      sb_push("mask_irq_any_expiry", 32'h1);
      rd_irq();
      sb_push("mask_ch3_pend", 32'h1);
      rd(3, 3);
      sb_push("mask_ch0_count", 32'h0);
      rd(0, 2);
      wr(3, 0, 32'h8);
      sb_push("mask_irq_unmasked", 32'h9);
      sb_push("mask_irq_any_unmasked", 32'h1);
      rd_irq();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_reset_midcount;
      exp_t e;
      logic [31:0] got;
      wr(0, 3, 32'h1);
      wr(3, 3, 32'h1);
      wr(2, 0, 32'h8);
      wr(0, 1, 32'd100);
      wr(0, 0, 32'h9);
      repeat (3) @(negedge clk);
      sb_push("rstmid_count_before", 32'd97);
      rd(0, 2);
      sb_push("rstmid_irq_before", 32'h4);
      sb_push("rstmid_irq_any_before", 32'h1);
      rd_irq();
      rst = 1'b1;
      #1;
      sb_push("rstmid_irq_async", 32'h0);
      sb_push("rstmid_irq_any_async", 32'h0);
      rd_irq();
      sb_push("rstmid_count", 32'h0);
      rd(0, 2);
      sb_push("rstmid_preset", 32'h0);
      rd(0, 1);
      sb_push("rstmid_ctrl", 32'h0);
      rd(0, 0);
      sb_push("rstmid_ch2_pend", 32'h0);
      rd(2, 3);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      sb_push("rstmid_count_after", 32'h0);
      rd(0, 2);
      sb_push("rstmid_ctrl_after", 32'h0);
      rd(0, 0);
      wr(0, 1, 32'd5);
      repeat (2) @(negedge clk);
      sb_push("rstmid_no_count_without_en", 32'd5);
      rd(0, 2);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_range;
      exp_t e;
      logic [31:0] got;
      wr3(0, 1, 32'h12345);
      wr3(1, 1, 32'h22);
      wr3(2, 1, 32'h33);
      wr3(0, 2, 32'h99);
      wr3(3, 1, 32'hAAAA);
      wr3(3, 0, 32'hF);
      wr3(3, 3, 32'h1);
      for (int r = 0; r < 4; r++) begin
         sb_push($sformatf("range_ch3_reg%0d", r), 32'h0);
         rd3(3, r);
      end
      sb_push("range_ch0_preset_trunc", 32'h2345);
      rd3(0, 1);
      sb_push("range_ch0_count_write_ignored", 32'h2345);
      rd3(0, 2);
      sb_push("range_ch1_preset", 32'h22);
      rd3(1, 1);
      sb_push("range_ch2_preset", 32'h33);
      rd3(2, 1);
      sb_push("range_ch1_ctrl", 32'h0);
      rd3(1, 0);
      sb_push("range_ch2_ctrl", 32'h0);
      rd3(2, 0);
      sb_push("range_irq3", 32'h0);
      obs.push_back({29'b0, irq3});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (obs.size() == 0) begin
            bad++;
            $display("FAIL %s: no observation, want %h", e.name, e.val);
         end else begin
            got = obs.pop_front();
            if (got !== e.val) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, got, e.val);
            end
         end
      end
      obs.delete();
   endtask

   initial begin
      rst      = 1'b1;
      we       = 1'b0;
      we3      = 1'b0;
      dev_addr = '0;
      a3       = '0;
      dev_wd   = '0;
      wd3      = '0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_one_shot();
      test_auto_reload();
      test_collision();
      test_mask();
      test_reset_midcount();
      test_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter N_CH, default 4, number of independent timer channels, legal range 1..16.
REQ-002 Parameter CNT_W, default 32, width of PRESET and COUNT per channel, legal range 8..32.
REQ-003 Derived constant CH_W = max(1, clog2(N_CH)), channel-index width.
REQ-004 Port clk, input, 1 -- single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 -- asynchronous, active-high reset.
REQ-006 Port dev_addr, input, CH_W+2 -- word address: bits [CH_W+1:2] select the channel, bits [1:0] select the register.
REQ-007 Port we, input, 1 -- write enable, one write per asserted cycle.
REQ-008 Port dev_wd, input, 32 -- write data.
REQ-009 Port dev_rd, output, 32 -- read data, combinational from dev_addr.
REQ-010 Port irq, output, N_CH -- per-channel interrupt, irq[i] = PEND[i] & IM[i].
REQ-011 Port irq_any, output, 1 -- OR of all irq bits.

Function
REQ-012 Register map per channel, by offset: 0 CTRL (R/W), 1 PRESET (R/W), 2 COUNT (read-only), 3 STATUS (read; write-1-to-clear).
REQ-013 CTRL bit fields: [0] EN; [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as one-shot and read back as written); [3] IM; bits [31:4] read 0.
REQ-014 STATUS bit fields: [0] PEND; bits [31:1] read 0; writing 1 to bit 0 clears PEND; writing 0 has no effect.
REQ-015 A write to PRESET loads PRESET and COUNT with dev_wd[CNT_W-1:0] on the same edge, whatever the value of EN.
REQ-016 Writes to COUNT are ignored.
REQ-017 While EN=1 and COUNT>1, COUNT decrements by 1 on every clk edge.
REQ-018 When EN=1 and COUNT=1, the next edge sets COUNT to 0 and sets PEND.
REQ-019 In one-shot mode, the same edge that reaches 0 also clears EN.
REQ-020 In auto-reload mode, with EN=1, COUNT=0 and PRESET!=0, the next edge loads COUNT from PRESET; the reload period is therefore PRESET+1 cycles.
REQ-021 With EN=1 and COUNT=0 (auto-reload with PRESET=0, or one-shot re-enabled at 0), COUNT holds and no PEND is generated.
REQ-022 A CTRL write takes effect from the next edge; a write that sets EN does not decrement on its own edge.
REQ-023 Simultaneous PEND set by terminal count and STATUS clear write on the same channel: set wins, PEND=1.
REQ-024 A PRESET write on the same edge as a terminal count: the write wins, PEND is still set, and the one-shot EN clear still applies.
REQ-025 A channel index >= N_CH reads 0 and ignores writes.
REQ-026 When we=0, no register changes except by counting; reads have no side effects.
REQ-027 Channels operate independently, and any number may assert irq in the same cycle.
REQ-028 Masking (IM=0) does not stop PEND from being set; setting IM later asserts irq immediately.

Reset
REQ-029 While rst=1, every channel holds CTRL=0, PRESET=0, COUNT=0 and PEND=0, so irq=0, irq_any=0 and dev_rd reflects the zeroed registers.
REQ-030 Reset asserted mid-count aborts counting immediately; after release, counting resumes only after software sets EN.

Structure
REQ-031 Shared package timer_pkg holds the register offsets (CTRL, PRESET, COUNT, STATUS), the MODE encodings and the CTRL/STATUS bit positions.
REQ-032 Sub-module timer_channel (one channel: CTRL, PRESET, COUNT, PEND and terminal-count logic) is instantiated N_CH times by a generate loop.
REQ-033 multi_timer contains only address decode, the read mux, and the irq/irq_any reduction.

Verification
REQ-034 Scenario 1 (one-shot): ch0 PRESET=5, CTRL=0x9 -> COUNT reads 4,3,2,1,0 on successive cycles; PEND=1, irq[0]=1 and EN=0 on the edge that reaches 0; COUNT then holds 0.
REQ-035 Scenario 2 (auto-reload): ch1 PRESET=3, CTRL=0xB -> PEND set every 4 cycles; W1C STATUS=1 clears irq[1] between terminal counts; the sequence 3,2,1,0,3 repeats.
REQ-036 Scenario 3 (collision): STATUS W1C on the same edge ch2 reaches 0 -> PEND stays 1; PRESET write on the terminal edge -> COUNT=new value and PEND=1.
REQ-037 Scenario 4 (masking and aggregation): ch0 and ch3 expire together with IM0=1, IM3=0 -> irq=4'b0001, irq_any=1; then set IM3 -> irq=4'b1001 without a new expiry.
REQ-038 Scenario 5 (reset and range): assert rst mid-count with PRESET=100 -> all registers 0 and irq=0 asynchronously; with N_CH=3, an access to channel 3 reads 0 and a write leaves all channels unchanged.
